wb_master_engine: RTL and testbench
===================================

WB_MASTER_ENGINE -- requirements
Module: wb_master_engine

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, 2, Wishbone address width.
REQ-002 SHALL have parameter DATA_WIDTH, 8, Wishbone data width.
REQ-003 SHALL have parameter FIFO_DEPTH, 4, command FIFO entries (power of two, >=2).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, 255, maximum wait cycles per command (>=1).
REQ-005 SHALL have ports: clk_i in 1 clock; rst_i in 1 reset. One clock; reset is synchronous and active-high.
REQ-006 SHALL have ports: cmd_valid_i in 1; cmd_ready_o out 1; cmd_op_i in 2 (00 write, 01 read, 10 wait-irq, 11 reserved); cmd_adr_i in ADDR_WIDTH; cmd_dat_i in DATA_WIDTH.
REQ-007 SHALL have ports: rsp_valid_o out 1; rsp_ready_i in 1; rsp_dat_o out DATA_WIDTH; rsp_err_o out 1 (timeout or reserved op).
REQ-008 SHALL have ports: cyc_o, stb_o, we_o out 1; adr_o out ADDR_WIDTH; dat_o out DATA_WIDTH; ack_i in 1; dat_i in DATA_WIDTH; irq_i in 1; busy_o out 1.

Function
REQ-009 SHALL accept a command on each rising edge with cmd_valid_i && cmd_ready_o; cmd_ready_o = FIFO not full, no same-cycle pop credit.
REQ-010 SHALL execute commands strictly in FIFO order, one at a time; every command yields exactly one response.
REQ-011 SHALL implement FSM states IDLE, BUS, IRQ, RESP; IDLE pops head when FIFO non-empty.
REQ-012 SHALL, on pop of write/read, enter BUS with cyc_o=stb_o=1, we_o=(op==00), adr_o/dat_o from command, all registered; dat_o=0 for reads.
REQ-013 SHALL, with an empty FIFO in IDLE, raise cyc_o the cycle after the edge that accepted the command (1-cycle latency).
REQ-014 SHALL, on the edge sampling ack_i=1 in BUS, capture dat_i (reads) or 0 (writes) into rsp_dat_o, deassert cyc_o/stb_o/we_o next cycle, enter RESP with rsp_err_o=0.
REQ-015 SHALL ignore ack_i outside BUS.
REQ-016 SHALL, on pop of wait-irq, enter IRQ with no bus activity; on edge sampling irq_i=1 enter RESP, rsp_dat_o=0, rsp_err_o=0; irq_i already high completes on first IRQ cycle.
REQ-017 SHALL treat op 11 as no-bus command: go directly to RESP with rsp_err_o=1, rsp_dat_o=0.
REQ-018 SHALL hold rsp_valid_o=1 and response fields stable in RESP until rsp_valid_o && rsp_ready_i, then return to IDLE; next pop no earlier than following cycle.
REQ-019 SHALL count cycles in BUS/IRQ from 1; when count reaches TIMEOUT_CYCLES without completion, drop cyc_o/stb_o next cycle, enter RESP with rsp_err_o=1, rsp_dat_o=0.
REQ-020 SHALL, when ack_i/irq_i and timeout coincide on the same edge, complete normally (rsp_err_o=0).
REQ-021 SHALL drive adr_o=0, dat_o=0, we_o=0 whenever cyc_o=0 (never X).
REQ-022 SHALL assert busy_o when FIFO non-empty or state != IDLE.
REQ-023 SHALL wrap FIFO pointers modulo FIFO_DEPTH; full and empty distinguished by an extra pointer bit.

Reset
REQ-024 SHALL, on rst_i=1 at a rising edge, enter IDLE, flush FIFO, clear timeout counter.
REQ-025 SHALL have reset values: cyc_o=stb_o=we_o=0, adr_o=dat_o=0, rsp_valid_o=0, rsp_dat_o=0, rsp_err_o=0, busy_o=0, cmd_ready_o=0 during reset then 1.
REQ-026 SHALL, on reset mid-transaction, abort without response; cyc_o low the cycle after the reset edge.

Configuration
REQ-027 SHALL compile timeout logic only when macro WB_MASTER_ENGINE_TIMEOUT_EN is defined.
REQ-028 SHALL, without WB_MASTER_ENGINE_TIMEOUT_EN, wait indefinitely in BUS/IRQ; rsp_err_o set only for op 11; TIMEOUT_CYCLES unused.

Verification
REQ-029 SHALL cover write adr=2 dat=0xA5, ack after 3 cycles -> cyc_o high 4 cycles, we_o=1, response err=0 dat=0x00.
REQ-030 SHALL cover read adr=1, slave returns 0x3C with ack -> rsp_dat_o=0x3C, err=0, we_o=0 throughout.
REQ-031 SHALL cover 5 back-to-back pushes, FIFO_DEPTH=4, no ack -> cmd_ready_o low after 4th accept, 5th accepted only after first pop.
REQ-032 SHALL cover TIMEOUT_EN, TIMEOUT_CYCLES=8, read with no ack -> cyc_o drops after 8 cycles, rsp_err_o=1, rsp_dat_o=0; next command then issued.
REQ-033 SHALL cover wait-irq, irq_i high 10 cycles later, rsp_ready_i low 3 cycles -> rsp_valid_o held 3+ cycles, dat=0, err=0.
REQ-034 SHALL cover rst_i mid-BUS with 2 queued commands -> cyc_o low next cycle, busy_o=0, no responses, FIFO empty.

Source files
------------

// File: rtl/wb_master_engine.sv
// Wishbone master command engine: a command FIFO feeding an FSM that runs write/read/wait-irq commands and returns one response per command.
// Optional per-command timeout is compiled in when WB_MASTER_ENGINE_TIMEOUT_EN is defined.
module wb_master_engine #(
    parameter int ADDR_WIDTH     = 2,
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [1:0]            cmd_op_i,
    input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
    input  logic [DATA_WIDTH-1:0] cmd_dat_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_dat_o,
    output logic                  rsp_err_o,
    output logic                  cyc_o,
    output logic                  stb_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] adr_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic                  ack_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic                  irq_i,
    output logic                  busy_o,
    output logic [1:0]            dbg_state_o
);
    // Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = 2 + ADDR_WIDTH + DATA_WIDTH;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("wb_master_engine: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_IRQ  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_cyc;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_adr;
    logic [DATA_WIDTH-1:0] r_dat;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_dat;
    logic                  r_rsp_err;
    logic [ENTRY_W-1:0]    r_mem [FIFO_DEPTH];
    logic [PTR_W:0]        r_wr_ptr;
    logic [PTR_W:0]        r_rd_ptr;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic [ENTRY_W-1:0]    w_head;
    logic [1:0]            w_head_op;
    logic [ADDR_WIDTH-1:0] w_head_adr;
    logic [DATA_WIDTH-1:0] w_head_dat;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign cmd_ready_o = !rst_i && !w_full;
    assign w_push  = cmd_valid_i && cmd_ready_o;
    // An empty FIFO forwards the incoming command straight to IDLE so the bus starts one cycle after acceptance.
    assign w_pop   = (r_state == S_IDLE) && (!w_empty || w_push);
    assign w_head  = w_empty ? {cmd_op_i, cmd_adr_i, cmd_dat_i} : r_mem[r_rd_ptr[PTR_W-1:0]];
    assign w_head_op  = w_head[ENTRY_W-1 -: 2];
    assign w_head_adr = w_head[DATA_WIDTH +: ADDR_WIDTH];
    assign w_head_dat = w_head[DATA_WIDTH-1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[PTR_W-1:0]] <= {cmd_op_i, cmd_adr_i, cmd_dat_i};
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

`ifdef WB_MASTER_ENGINE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b0;
`ifdef WB_MASTER_ENGINE_TIMEOUT_EN
            r_cnt       <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
`ifdef WB_MASTER_ENGINE_TIMEOUT_EN
                        r_cnt <= CNT_W'(1);
`endif
                        case (w_head_op)
                            2'b00, 2'b01: begin
                                r_cyc   <= 1'b1;
                                r_we    <= (w_head_op == 2'b00);
                                r_adr   <= w_head_adr;
                                r_dat   <= (w_head_op == 2'b00) ? w_head_dat : '0;
                                r_state <= S_BUS;
                            end
                            2'b10: r_state <= S_IRQ;
                            default: begin
                                r_rsp_valid <= 1'b1;
                                r_rsp_dat   <= '0;
                                r_rsp_err   <= 1'b1;
                                r_state     <= S_RESP;
                            end
                        endcase
                    end
                end
                S_BUS: begin
                    if (ack_i) begin
                        r_cyc       <= 1'b0;
                        r_we        <= 1'b0;
                        r_adr       <= '0;
                        r_dat       <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_dat   <= r_we ? '0 : dat_i;
                        r_rsp_err   <= 1'b0;
                        r_state     <= S_RESP;
                    end
`ifdef WB_MASTER_ENGINE_TIMEOUT_EN
                    else if (r_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
                        r_cyc       <= 1'b0;
                        r_we        <= 1'b0;
                        r_adr       <= '0;
                        r_dat       <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_dat   <= '0;
                        r_rsp_err   <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                S_IRQ: begin
                    if (irq_i) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_dat   <= '0;
                        r_rsp_err   <= 1'b0;
                        r_state     <= S_RESP;
                    end
`ifdef WB_MASTER_ENGINE_TIMEOUT_EN
                    else if (r_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_dat   <= '0;
                        r_rsp_err   <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_dat   <= '0;
                        r_rsp_err   <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cyc_o       = r_cyc;
    assign stb_o       = r_cyc;
    assign we_o        = r_we;
    assign adr_o       = r_adr;
    assign dat_o       = r_dat;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_dat_o   = r_rsp_dat;
    assign rsp_err_o   = r_rsp_err;
    assign busy_o      = (r_state != S_IDLE) || !w_empty;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_wb_master_engine.sv
// Directed bench for wb_master_engine: a vector table of single commands plus FIFO-full, response back-pressure and reset sequences.
// Timeout vectors are added when WB_MASTER_ENGINE_TIMEOUT_EN is defined (TIMEOUT_CYCLES = 8).
module tb_wb_master_engine;
    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic [1:0] cmd_op_i;
    logic [1:0] cmd_adr_i;
    logic [7:0] cmd_dat_i;
    logic       rsp_valid_o;
    logic       rsp_ready_i;
    logic [7:0] rsp_dat_o;
    logic       rsp_err_o;
    logic       cyc_o, stb_o, we_o;
    logic [1:0] adr_o;
    logic [7:0] dat_o;
    logic       ack_i;
    logic [7:0] dat_i;
    logic       irq_i;
    logic       busy_o;
    logic [1:0] dbg_state_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [1:0] op;
        logic [1:0] adr;
        logic [7:0] dat;
        int         delay;
        logic [7:0] sdat;
        int         exp_cyc;
        logic [7:0] exp_dat;
        logic       exp_err;
    } vec_t;

    wb_master_engine #(
        .ADDR_WIDTH(2), .DATA_WIDTH(8), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
        .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
        .rsp_err_o(rsp_err_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
        .ack_i(ack_i), .dat_i(dat_i), .irq_i(irq_i), .busy_o(busy_o),
        .dbg_state_o(dbg_state_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Returns at the sample point just after the edge that accepted the command.
    task automatic push_cmd(input logic [1:0] op, input logic [1:0] adr, input logic [7:0] dat);
        bit acc = 0;
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_adr_i   = adr;
        cmd_dat_i   = dat;
        for (int i = 0; i < 100 && !acc; i++) begin
            acc = cmd_ready_o;
            step();
        end
        cmd_valid_i = 1'b0;
        if (!acc) check("push_accept", 0, 1);
    endtask

    task automatic run_cmd(input vec_t v);
        int         cyc_cnt = 0;
        bit         bus_bad = 0;
        bit         done = 0;
        logic       exp_we;
        logic [7:0] exp_dout;
        exp_we   = (v.op == 2'b00);
        exp_dout = (v.op == 2'b00) ? v.dat : 8'h00;
        rsp_ready_i = 1'b1;
        push_cmd(v.op, v.adr, v.dat);
        check("latency", {31'b0, cyc_o}, {31'b0, (v.op == 2'b00 || v.op == 2'b01)});
        for (int i = 0; i < 300 && !done; i++) begin
            if (cyc_o) begin
                cyc_cnt++;
                if (stb_o !== 1'b1 || we_o !== exp_we || adr_o !== v.adr || dat_o !== exp_dout) bus_bad = 1;
            end else if (stb_o !== 1'b0 || we_o !== 1'b0 || adr_o !== 2'd0 || dat_o !== 8'd0) begin
                bus_bad = 1;
            end
            ack_i = cyc_o && (cyc_cnt == v.delay + 1);
            dat_i = ack_i ? v.sdat : 8'hEE;
            irq_i = (v.op == 2'b10) && (i >= v.delay);
            if (rsp_valid_o) begin
                check("rsp_dat", rsp_dat_o, v.exp_dat);
                check("rsp_err", rsp_err_o, v.exp_err);
                done = 1;
            end
            step();
        end
        ack_i = 1'b0;
        irq_i = 1'b0;
        if (!done) check("rsp_wait_bound", 0, 1);
        check("cyc_cycles", cyc_cnt, v.exp_cyc);
        check("bus_fields", {31'b0, bus_bad}, 0);
        check("rsp_drop", {31'b0, rsp_valid_o}, 0);
    endtask

    // Immediate-ack slave returning 0x10 + adr; responses are matched against exp_q in order.
    task automatic drain(input int max_cyc);
        for (int i = 0; i < max_cyc && (exp_q.size() > 0 || busy_o); i++) begin
            ack_i = cyc_o;
            dat_i = cyc_o ? (8'h10 + {6'b0, adr_o}) : 8'hEE;
            if (rsp_valid_o) begin
                if (exp_q.size() == 0) check("drain_extra_rsp", 1, 0);
                else check("drain_rsp", rsp_dat_o, exp_q.pop_front());
            end
            step();
        end
        ack_i = 1'b0;
        check("drain_q_empty", exp_q.size(), 0);
        check("drain_idle", {31'b0, busy_o}, 0);
    endtask

    initial begin
        vec_t vecs[$];
        int   n_acc;
        int   w;
        int   irq_dly;
        bit   bad;

        vecs.push_back('{op: 2'b00, adr: 2'd2, dat: 8'hA5, delay: 3, sdat: 8'h99, exp_cyc: 4, exp_dat: 8'h00, exp_err: 1'b0});
        vecs.push_back('{op: 2'b01, adr: 2'd1, dat: 8'h00, delay: 0, sdat: 8'h3C, exp_cyc: 1, exp_dat: 8'h3C, exp_err: 1'b0});
        vecs.push_back('{op: 2'b01, adr: 2'd3, dat: 8'h5A, delay: 5, sdat: 8'hC3, exp_cyc: 6, exp_dat: 8'hC3, exp_err: 1'b0});
        vecs.push_back('{op: 2'b11, adr: 2'd1, dat: 8'h55, delay: 0, sdat: 8'h00, exp_cyc: 0, exp_dat: 8'h00, exp_err: 1'b1});
        vecs.push_back('{op: 2'b10, adr: 2'd0, dat: 8'h00, delay: 0, sdat: 8'h00, exp_cyc: 0, exp_dat: 8'h00, exp_err: 1'b0});
        vecs.push_back('{op: 2'b10, adr: 2'd2, dat: 8'h77, delay: 4, sdat: 8'h00, exp_cyc: 0, exp_dat: 8'h00, exp_err: 1'b0});
        vecs.push_back('{op: 2'b00, adr: 2'd0, dat: 8'hFF, delay: 1, sdat: 8'h42, exp_cyc: 2, exp_dat: 8'h00, exp_err: 1'b0});
`ifdef WB_MASTER_ENGINE_TIMEOUT_EN
        vecs.push_back('{op: 2'b01, adr: 2'd2, dat: 8'h00, delay: 1000, sdat: 8'h00, exp_cyc: 8, exp_dat: 8'h00, exp_err: 1'b1});
        vecs.push_back('{op: 2'b01, adr: 2'd1, dat: 8'h00, delay: 7, sdat: 8'h5A, exp_cyc: 8, exp_dat: 8'h5A, exp_err: 1'b0});
        vecs.push_back('{op: 2'b01, adr: 2'd3, dat: 8'h00, delay: 0, sdat: 8'h81, exp_cyc: 1, exp_dat: 8'h81, exp_err: 1'b0});
        irq_dly = 5;
`else
        irq_dly = 10;
`endif

        rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_op_i = 2'b00; cmd_adr_i = 2'd0; cmd_dat_i = 8'h00;
        rsp_ready_i = 1'b1; ack_i = 1'b0; dat_i = 8'h00; irq_i = 1'b0;
        step();
        step();
        check("reset_ready", {31'b0, cmd_ready_o}, 0);
        check("reset_bus", {20'b0, cyc_o, stb_o, we_o, adr_o, dat_o, 1'b0}, 0);
        check("reset_rsp", {22'b0, rsp_valid_o, rsp_err_o, rsp_dat_o}, 0);
        check("reset_busy", {31'b0, busy_o}, 0);
        rst_i = 1'b0;
        step();
        check("ready_after_reset", {31'b0, cmd_ready_o}, 1);

        foreach (vecs[k]) run_cmd(vecs[k]);

        // FIFO full: one read in flight, four queued, the fifth waits for a pop.
        rsp_ready_i = 1'b1;
        push_cmd(2'b01, 2'd0, 8'h00);
        n_acc = 0;
        for (int k = 0; k < 4; k++) begin
            cmd_valid_i = 1'b1; cmd_op_i = 2'b01; cmd_adr_i = 2'(k + 1); cmd_dat_i = 8'h00;
            if (cmd_ready_o) begin
                n_acc++;
                exp_q.push_back(8'h10 + 8'((k + 1) % 4));
            end
            step();
        end
        check("full_accepts", n_acc, 4);
        check("full_ready_low", {31'b0, cmd_ready_o}, 0);
        cmd_valid_i = 1'b1; cmd_op_i = 2'b01; cmd_adr_i = 2'd1;
        step();
        check("full_stall", {31'b0, cmd_ready_o}, 0);
        ack_i = 1'b1; dat_i = 8'h77;
        step();
        ack_i = 1'b0;
        check("full_first_rsp", {23'b0, rsp_valid_o, rsp_dat_o}, {23'b0, 1'b1, 8'h77});
        step();
        w = 0;
        while (!cmd_ready_o && w < 20) begin
            step();
            w++;
        end
        check("full_pop_wait", w, 1);
        step();
        cmd_valid_i = 1'b0;
        exp_q.push_back(8'h11);
        drain(200);

        // Wait-irq with response back-pressure.
        rsp_ready_i = 1'b0;
        push_cmd(2'b10, 2'd0, 8'h00);
        w = 0;
        while (!rsp_valid_o && w < 50) begin
            irq_i = (w >= irq_dly);
            step();
            w++;
        end
        irq_i = 1'b0;
        check("irq_rsp_time", w, irq_dly + 1);
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            if (rsp_valid_o !== 1'b1 || rsp_dat_o !== 8'h00 || rsp_err_o !== 1'b0) bad = 1;
            step();
        end
        check("rsp_hold", {31'b0, bad}, 0);
        check("rsp_still_valid", {31'b0, rsp_valid_o}, 1);
        rsp_ready_i = 1'b1;
        step();
        check("rsp_released", {31'b0, rsp_valid_o}, 0);

        // Reset mid-BUS with two commands queued.
        push_cmd(2'b01, 2'd2, 8'h00);
        push_cmd(2'b00, 2'd1, 8'h12);
        push_cmd(2'b01, 2'd3, 8'h00);
        check("pre_reset_cyc", {31'b0, cyc_o}, 1);
        rst_i = 1'b1;
        step();
        check("rst_cyc_low", {31'b0, cyc_o}, 0);
        check("rst_busy_low", {31'b0, busy_o}, 0);
        rst_i = 1'b0;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (rsp_valid_o !== 1'b0 || cyc_o !== 1'b0 || busy_o !== 1'b0) bad = 1;
        end
        check("rst_no_activity", {31'b0, bad}, 0);
        check("rst_ready", {31'b0, cmd_ready_o}, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
